// File: rtl/timer_mc.sv
// Multi-channel capture timer: one shared free-running counter, NUM_CH capture
// channels with valid/overrun status, start/stop control and a one-shot or periodic alarm.
module timer_mc #(
    parameter int CNT_W  = 32,
    parameter int NUM_CH = 4
) (
    input  logic                    clk,
    input  logic                    rst_an,
    input  logic                    clr,
    input  logic                    start,
    input  logic                    stop,
    input  logic [NUM_CH-1:0]       capture,
    input  logic [NUM_CH-1:0]       rst_capture,
    input  logic                    alarm_en,
    input  logic                    alarm_periodic,
    input  logic [CNT_W-1:0]        alarm,
    output logic [CNT_W-1:0]        counter,
    output logic [NUM_CH*CNT_W-1:0] captured,
    output logic [NUM_CH-1:0]       capture_valid,
    output logic [NUM_CH-1:0]       capture_ovr,
    output logic                    overflow,
    output logic                    running,
    output logic                    alarm_out
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_RUN     = 2'd1;
    localparam logic [1:0] ST_STOPPED = 2'd2;

    logic [1:0]                   state_q, state_d;
    logic                         start_q, stop_q;
    logic [NUM_CH-1:0]            cap_q;
    logic [CNT_W-1:0]             cnt_q, cnt_d;
    logic                         ovf_q, ovf_d;
    logic                         armed_q, armed_d;
    logic                         alarm_q, alarm_d;
    logic                         reload_q, reload_d;
    logic [NUM_CH-1:0][CNT_W-1:0] captured_q, captured_d;
    logic [NUM_CH-1:0]            valid_q, valid_d;
    logic [NUM_CH-1:0]            ovr_q, ovr_d;

    logic              start_edge, stop_edge, match, cap_allowed;
    logic [NUM_CH-1:0] cap_edge;

    assign start_edge  = start & ~start_q;
    assign stop_edge   = stop & ~stop_q;
    assign cap_edge    = capture & ~cap_q;
    assign cap_allowed = (state_q != ST_IDLE) || start_edge;

    // NOTE: every next-state signal is given its hold value first, so no path through this block can infer a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
        match      = 1'b0;
        captured_d = captured_q;
        valid_d    = valid_q;
        ovr_d      = ovr_q;

        if (start_edge) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            ovf_d   = 1'b0;
            match   = alarm_en && (alarm == '0);
        end else if (state_q == ST_RUN) begin
            // The cycle after a periodic match reloads instead of counting, so it never wraps.
            if (reload_q) begin
                cnt_d = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (&cnt_q) ovf_d = 1'b1;
            end
            match = armed_q && alarm_en && (cnt_d == alarm);
            if (stop_edge) state_d = ST_STOPPED;
        end

        armed_d  = (start_edge ? alarm_en : (armed_q & alarm_en)) & ~(match & ~alarm_periodic);
        alarm_d  = match;
        reload_d = match & alarm_periodic;

        for (int i = 0; i < NUM_CH; i++) begin
            if (rst_capture[i]) begin
                captured_d[i] = '0;
                valid_d[i]    = 1'b0;
                ovr_d[i]      = 1'b0;
            end else if (cap_edge[i] && cap_allowed) begin
                captured_d[i] = cnt_d;
                valid_d[i]    = 1'b1;
                ovr_d[i]      = ovr_q[i] | valid_q[i];
            end
        end
    end

    // NOTE: the capture registers are few and must read 0 after reset, so they are reset like every other flop.
    always_ff @(posedge clk or negedge rst_an) begin
        if (!rst_an) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            cap_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            armed_q    <= 1'b0;
            alarm_q    <= 1'b0;
            reload_q   <= 1'b0;
            captured_q <= '0;
            valid_q    <= '0;
            ovr_q      <= '0;
        end else if (clr) begin
            state_q    <= ST_IDLE;
            start_q    <= 1'b0;
            stop_q     <= 1'b0;
            cap_q      <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
            armed_q    <= 1'b0;
            alarm_q    <= 1'b0;
            reload_q   <= 1'b0;
            captured_q <= '0;
            valid_q    <= '0;
            ovr_q      <= '0;
        end else begin
            state_q    <= state_d;
            start_q    <= start;
            stop_q     <= stop;
            cap_q      <= capture;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
            armed_q    <= armed_d;
            alarm_q    <= alarm_d;
            reload_q   <= reload_d;
            captured_q <= captured_d;
            valid_q    <= valid_d;
            ovr_q      <= ovr_d;
        end
    end

    assign counter       = cnt_q;
    assign captured      = captured_q;
    assign capture_valid = valid_q;
    assign capture_ovr   = ovr_q;
    assign overflow      = ovf_q;
    assign running       = (state_q == ST_RUN);
    assign alarm_out     = alarm_q;

endmodule

// File: doc/timer_mc.md
Name: timer_mc

Overview:
- Parametrised multi-channel successor to the single-channel timer.
- One free-running counter of configurable width is shared by NUM_CH independent capture channels.
- Adds a stop control, a sticky overflow flag, per-channel capture-valid and overrun status, and a one-shot or periodic alarm.
- Sits beside the existing timer in the datapath and is driven by the same start/capture pulse sources.

Parameters:
- CNT_W, 32, counter, alarm and capture width in bits (8..64).
- NUM_CH, 4, number of capture channels (1..16).

Ports:
- clk  in  1  system clock (122 MHz nominal)
- rst_an  in  1  asynchronous active-low reset
- clr  in  1  synchronous clear, active high; same effect as reset, applied on the clk edge
- start  in  1  level input; rising edge (re)starts the count from 0
- stop  in  1  level input; rising edge freezes the counter
- capture  in  NUM_CH  per-channel level input; rising edge captures
- rst_capture  in  NUM_CH  per-channel synchronous clear of the capture register and its status
- alarm_en  in  1  alarm enable
- alarm_periodic  in  1  0 = one-shot, 1 = periodic reload
- alarm  in  CNT_W  alarm compare value
- counter  out  CNT_W  current count
- captured  out  NUM_CH*CNT_W  capture registers; channel i occupies bits [i*CNT_W +: CNT_W]
- capture_valid  out  NUM_CH  sticky flag: channel holds a capture
- capture_ovr  out  NUM_CH  sticky flag: capture occurred while valid was already set
- overflow  out  1  sticky flag: counter wrapped
- running  out  1  high in state RUN
- alarm_out  out  1  single-cycle alarm pulse

Behaviour:
- Reset (rst_an low, asynchronous) and clr (synchronous) set the following to 0:
  - state IDLE
  - counter, captured, capture_valid, capture_ovr, overflow, alarm_out, alarm_armed
  - all edge-detect registers
- Edge detect: start, stop and each capture bit are registered once. A rising edge at posedge E means the input is sampled 1 at E and was sampled 0 at E-1. Held-high levels produce exactly one event.
- FSM states: IDLE, RUN, STOPPED.
  - IDLE -> RUN on a start edge.
  - RUN -> STOPPED on a stop edge.
  - STOPPED -> RUN on a start edge.
  - The start edge has priority over a simultaneous stop edge (restart).
  - A stop edge in IDLE or STOPPED is ignored.
- Counter:
  - On a start edge: counter <= 0, overflow <= 0, alarm_armed <= alarm_en.
  - In RUN otherwise: counter <= counter+1 modulo 2^CNT_W.
  - Wrap from all-ones to 0 sets overflow; overflow stays set until the next start, clr or reset.
  - In STOPPED the counter holds. In IDLE it stays 0.
- Capture, channel i, on a capture edge at posedge E:
  - In RUN: captured[i] <= value the counter takes at E. The captured value therefore equals the number of posedges from the start edge to the capture edge; a capture on the same edge as start yields 0.
  - In STOPPED: captured[i] <= held counter.
  - In IDLE: ignored, no flag change.
  - If capture_valid[i] is already 1: capture_ovr[i] <= 1 and the register is overwritten.
  - capture_valid[i] <= 1.
  - rst_capture[i] clears captured[i], capture_valid[i] and capture_ovr[i]. It has priority over a simultaneous capture edge on the same channel.
  - Channels are fully independent.
- Alarm:
  - Match condition: RUN, alarm_armed, and the next counter value equals alarm.
  - alarm_out is registered; it is high for exactly the one cycle in which counter == alarm.
  - One-shot mode: on match, alarm_armed <= 0; no further pulses until the next start.
  - Periodic mode: the counter reloads to 0 on the edge after the match cycle instead of incrementing. Pulses repeat every alarm+1 cycles; overflow never sets.
  - alarm_periodic is sampled each cycle; changing it mid-run takes effect at the next match.
  - Deasserting alarm_en clears alarm_armed and blocks alarm_out from the next edge.
  - alarm = 0 fires on the start edge itself, because the counter becomes 0 there.
- Reset asserted mid-run: all outputs go to 0 immediately (asynchronously); the FSM returns to IDLE.
- Output latency: all outputs are registered, with no combinational path from inputs to outputs.

Test Plan:
- Reset, then start pulse (1 clk), capture[0] edge 100 clks after start -> captured[0]=100, capture_valid=4'b0001, running=1.
- Start held high 5 clks; capture[2] edge at +20; stop edge at +30; capture[3] at +40 -> captured[2]=20, captured[3]=30, counter frozen at 30, running=0.
- Second capture[0] edge at +150 -> captured[0]=150, capture_ovr[0]=1; then rst_capture[0] together with a capture[0] edge -> channel 0 all zero.
- CNT_W=8: run 300 clks -> counter=44 (300 mod 256), overflow=1; a start edge clears overflow and counter.
- alarm_en=1, alarm=10, one-shot -> single alarm_out pulse while counter==10, none after wrap. Periodic mode -> pulses every 11 cycles, counter sequence 0..10,0.
- Reset asserted mid-run with captures pending -> all outputs 0 without a clock edge; start and capture edges ignored until rst_an is released.
